// File: rtl/mem2wb_buffer.sv
// mem2wb_buffer: elastic MEM->WB pipeline buffer.
// Circular FIFO with write/read pointers and an occupancy counter. The buffer
// side presents only registered state to WB. Optional feature macro
// MEM2WB_BUFFER_BYPASS_EN forwards the MEM payload straight to WB while the
// buffer is empty; when WB takes it in the same cycle it is never stored.

package mem2wb_pkg;

    // Payload handed from MEM to WB.
    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_we;
        logic [31:0] pc;
        logic        instr_valid;
    } mem2wb_t;

endpackage

module mem2wb_buffer #(
    parameter int DEPTH         = 2,
    parameter int PAYLOAD_WIDTH = $bits(mem2wb_pkg::mem2wb_t),
    parameter int CNT_WIDTH     = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]     level
);

    localparam int                   PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    // Storage is deliberately left unreset; out_data is meaningless while empty.
    logic [PAYLOAD_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] level_q, level_d;
    // Holds in_ready low from reset until the first edge after rst drops.
    logic                 ready_en_q;

    logic buf_valid;
    logic buf_full;
    logic push;
    logic push_buf;
    logic pop_buf;
    logic bypass_take;

    assign buf_valid = (level_q != '0);
    assign buf_full  = (level_q == DEPTH_C);

    // When full, a same-cycle pop frees the slot the push lands in.
    assign in_ready  = ready_en_q & ~flush & (~buf_full | out_ready);
    assign push      = in_valid & in_ready;
    assign level     = level_q;

`ifdef MEM2WB_BUFFER_BYPASS_EN
    logic bypass_act;

    // Forwarding only while empty, out of reset and not being flushed.
    assign bypass_act  = ready_en_q & ~flush & ~buf_valid;
    assign out_valid   = buf_valid | (bypass_act & in_valid);
    assign out_data    = buf_valid ? mem_q[rd_ptr_q] : in_data;
    // Payload consumed directly by WB: neither stored nor counted.
    assign bypass_take = bypass_act & in_valid & out_ready;
`else
    assign out_valid   = buf_valid;
    assign out_data    = mem_q[rd_ptr_q];
    assign bypass_take = 1'b0;
`endif

    assign push_buf = push & ~bypass_take;
    assign pop_buf  = buf_valid & out_ready & ~flush;

    // Next-state for pointers and occupancy; flush overrides any handshake.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_buf) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_buf) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_buf, pop_buf})
                2'b10:   level_d = level_q + CNT_WIDTH'(1);
                2'b01:   level_d = level_q - CNT_WIDTH'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ready_en_q <= 1'b1;
        end
    end

    // Payload write into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push_buf) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: doc/mem2wb_buffer.md
MEM2WB_BUFFER -- requirements
Module: mem2wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of payload entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter PAYLOAD_WIDTH, default $bits(mem2wb_pkg::mem2wb_t), meaning width of the MEM->WB payload carried.
REQ-003 SHALL have parameter CNT_WIDTH, default $clog2(DEPTH)+1, meaning occupancy counter width.
REQ-004 SHALL have port clk, input, 1 bit: single core clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1 bit: discard all buffered entries (pipeline kill).
REQ-007 SHALL have port in_valid, input, 1 bit: MEM stage presents a payload.
REQ-008 SHALL have port in_ready, output, 1 bit: buffer accepts a payload this cycle.
REQ-009 SHALL have port in_data, input, PAYLOAD_WIDTH bits: payload from MEM.
REQ-010 SHALL have port out_valid, output, 1 bit: payload presented to WB.
REQ-011 SHALL have port out_ready, input, 1 bit: WB consumes the payload this cycle.
REQ-012 SHALL have port out_data, output, PAYLOAD_WIDTH bits: oldest payload.
REQ-013 SHALL have port level, output, CNT_WIDTH bits: current entry count.

Function
REQ-014 SHALL implement a circular FIFO with write pointer, read pointer and occupancy counter, each log2(DEPTH) bits wide (counter CNT_WIDTH) and wrapping modulo DEPTH.
REQ-015 SHALL complete a push when in_valid and in_ready are both 1, and a pop when out_valid and out_ready are both 1.
REQ-016 SHALL drive in_ready = (level < DEPTH) OR out_ready, so a push is accepted when full provided a pop occurs in the same cycle.
REQ-017 SHALL drive out_valid = (level != 0) and out_data = entry at the read pointer, both registered-path only (no in->out combinational path).
REQ-018 SHALL, on simultaneous push and pop, leave level unchanged and advance both pointers.
REQ-019 SHALL give one-cycle latency: a payload pushed in cycle N is visible on out_data in cycle N+1 at the earliest.
REQ-020 SHALL preserve strict FIFO order, with no payload duplicated or dropped.
REQ-021 SHALL, when flush=1, set level to 0 and both pointers to 0 at the next edge, ignoring any push or pop in that cycle.
REQ-022 SHALL hold in_ready=0 during a flush cycle.
REQ-023 SHALL ignore pushes when in_ready=0 and pops when out_valid=0 (no underflow or overflow).
REQ-024 SHALL keep out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-025 SHALL, on rst=1 regardless of clk, set level=0, both pointers=0, out_valid=0 and in_ready=0.
REQ-026 SHALL leave storage array contents unreset; out_data is don't-care while out_valid=0.
REQ-027 SHALL, when rst asserts mid-transfer, discard all entries; the first post-reset push is accepted one cycle after rst deasserts.

Configuration
REQ-028 SHALL, when macro MEM2WB_BUFFER_BYPASS_EN is defined and level=0, forward in_data/in_valid combinationally to out_data/out_valid; if out_ready=1 the payload is not stored (zero latency), otherwise it is stored normally.
REQ-029 SHALL, without MEM2WB_BUFFER_BYPASS_EN, have no combinational in->out path, with latency exactly as in REQ-019.
REQ-030 SHALL, with bypass enabled, suppress the bypass during a flush cycle (out_valid=0).

Verification
REQ-031 SHALL pass reset: assert rst mid-cycle with level=2 -> level=0, out_valid=0 immediately, in_ready=1 one cycle after release.
REQ-032 SHALL pass fill/drain: DEPTH=4, push 0xA1..0xA4 with out_ready=0 -> level=4, in_ready=0; then out_ready=1 -> outputs A1, A2, A3, A4 in order over 4 cycles.
REQ-033 SHALL pass full with simultaneous push/pop: level=4, push 0xB5 with out_ready=1 -> A1 popped, B5 stored, level stays 4.
REQ-034 SHALL pass wrap-around: 10 back-to-back push/pop pairs with DEPTH=2 -> pointers wrap, data order intact, level=1 steady.
REQ-035 SHALL pass flush with push: level=3, flush=1 with in_valid=1 -> next cycle level=0, out_valid=0, pushed payload discarded.
REQ-036 SHALL pass bypass: with MEM2WB_BUFFER_BYPASS_EN, empty buffer, in_valid=1 with 0xC3 and out_ready=1 -> out_data=0xC3 in the same cycle, level stays 0.
